// File: rtl/lsu_bus_master_pkg.sv
// Shared types for the memory-stage bus initiator: pipeline bundle, access
// sizes, FSM states and the alignment rule.
package lsu_bus_master_pkg;

  // Bit 2 selects zero-extension, bits [1:0] the access size.
  typedef enum logic [2:0] {
    LoadByte  = 3'b000,
    LoadHalf  = 3'b001,
    LoadWord  = 3'b010,
    ULoadByte = 3'b100,
    ULoadHalf = 3'b101
  } MemType;

  // Stores reuse the signed encodings; only the size matters for them.
  localparam MemType StoreByte = LoadByte;
  localparam MemType StoreHalf = LoadHalf;
  localparam MemType StoreWord = LoadWord;

  // Pipeline bundle between execute and writeback. For memory ops wdata
  // carries the byte address on the way in and the result on the way out.
  typedef struct packed {
    logic        valid;
    logic        memr;
    logic        memw;
    MemType      memt;
    logic [4:0]  rd;
    logic [31:0] reg2;
    logic [32:0] wdata;
  } Signals;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } LsuState;

  // Halves need a[0]=0, words need a[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(MemType memt, logic [1:0] addr_lo);
    logic mis;
    case (memt)
      LoadHalf, ULoadHalf: mis = addr_lo[0];
      LoadWord:            mis = (addr_lo != 2'b00);
      default:             mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_bus_master_mem_lane_align.sv
// Byte-lane steering for a 32-bit bus: strobes, store shifting, load
// extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import lsu_bus_master_pkg::*;
(
  input  MemType      memt,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [4:0]  shift,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misaligned
);

  logic [31:0] rdata_sh;

  // Lane enables and shift amount from access size and low address bits.
  always_comb begin
    strb  = 4'b1111;
    shift = 5'd0;
    case (memt)
      LoadByte, ULoadByte: begin
        strb  = 4'b0001 << addr_lo;
        shift = {addr_lo, 3'b000};
      end
      LoadHalf, ULoadHalf: begin
        strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
        shift = {addr_lo[1], 4'b0000};
      end
      default: begin
        strb  = 4'b1111;
        shift = 5'd0;
      end
    endcase
  end

  assign store_word = reg2 << shift;
  assign rdata_sh   = rdata >> shift;
  assign misaligned = is_misaligned(memt, addr_lo);

  // Extract the addressed field and extend it; words have shift 0.
  always_comb begin
    load_word = rdata_sh;
    case (memt)
      LoadByte:  load_word = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      ULoadByte: load_word = {24'h0, rdata_sh[7:0]};
      LoadHalf:  load_word = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      ULoadHalf: load_word = {16'h0, rdata_sh[15:0]};
      default:   load_word = rdata_sh;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Memory-stage bus initiator: issues one load/store at a time on a
// valid/ready word bus, stalls upstream while it is outstanding, and
// returns the aligned/extended load result to the pipeline.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  Signals               i_signals,
  output Signals               o_signals,
  output logic                 o_stall,
  output logic                 o_fault,
  output logic [ADDR_BITS-1:0] o_fault_addr,
  output logic                 o_req_valid,
  input  logic                 i_req_ready,
  output logic [ADDR_BITS-1:0] o_req_addr,
  output logic                 o_req_we,
  output logic [3:0]           o_req_strb,
  output logic [31:0]          o_req_wdata,
  input  logic                 i_rsp_valid,
  input  logic [31:0]          i_rsp_rdata
);

  LsuState              state_q, state_d;
  Signals               sig_q, sig_d;
  Signals               out_q, out_d;
  logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [3:0]           req_strb_q, req_strb_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic                 req_we_q, req_we_d;
  logic [31:0]          result_q, result_d;
  logic                 fault_q, fault_d;
  logic [ADDR_BITS-1:0] fault_addr_q, fault_addr_d;

  MemType               al_memt;
  logic [1:0]           al_addr_lo;
  logic [31:0]          al_reg2;
  logic [3:0]           al_strb;
  logic [4:0]           al_shift;
  logic [31:0]          al_store_word;
  logic [31:0]          al_load_word;
  logic                 al_misaligned;

  logic [ADDR_BITS-1:0] in_addr;
  logic                 in_is_mem;

  assign in_addr   = i_signals.wdata[ADDR_BITS-1:0];
  assign in_is_mem = i_signals.valid & (i_signals.memr ^ i_signals.memw);

  // Aligner looks at the incoming op while idle, the latched op otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      al_memt    = i_signals.memt;
      al_addr_lo = i_signals.wdata[1:0];
      al_reg2    = i_signals.reg2;
    end else begin
      al_memt    = sig_q.memt;
      al_addr_lo = sig_q.wdata[1:0];
      al_reg2    = sig_q.reg2;
    end
  end

  mem_lane_align u_align (
    .memt       (al_memt),
    .addr_lo    (al_addr_lo),
    .reg2       (al_reg2),
    .rdata      (i_rsp_rdata),
    .strb       (al_strb),
    .shift      (al_shift),
    .store_word (al_store_word),
    .load_word  (al_load_word),
    .misaligned (al_misaligned)
  );

  // Shift amount is folded into store_word/load_word; not needed here.
  logic unused_shift;
  assign unused_shift = ^al_shift;

  // Next-state, bus request and stall decode.
  always_comb begin
    state_d      = state_q;
    sig_d        = sig_q;
    out_d        = out_q;
    req_addr_d   = req_addr_q;
    req_strb_d   = req_strb_q;
    req_wdata_d  = req_wdata_q;
    req_we_d     = req_we_q;
    result_d     = result_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    o_stall      = 1'b0;
    o_req_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_is_mem) begin
          out_d = '0;
          if (al_misaligned) begin
            fault_d      = 1'b1;
            fault_addr_d = in_addr;
          end else begin
            o_stall     = 1'b1;
            state_d     = REQ;
            sig_d       = i_signals;
            req_addr_d  = {in_addr[ADDR_BITS-1:2], 2'b00};
            req_strb_d  = al_strb;
            req_wdata_d = al_store_word;
            req_we_d    = i_signals.memw;
            result_d    = 32'h0;
          end
        end else begin
          out_d = i_signals;
        end
      end
      REQ: begin
        o_stall     = 1'b1;
        o_req_valid = 1'b1;
        // Any response seen here is illegal and dropped.
        if (i_req_ready) state_d = sig_q.memw ? DONE : WAIT;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_rsp_valid) begin
          result_d = al_load_word;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Upstream still presents the finished op this cycle; ignore it.
        out_d       = sig_q;
        out_d.valid = 1'b1;
        out_d.wdata = {1'b0, result_q};
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sig_q        <= '0;
      out_q        <= '0;
      req_addr_q   <= '0;
      req_strb_q   <= '0;
      req_wdata_q  <= '0;
      req_we_q     <= 1'b0;
      result_q     <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_d;
      out_q        <= out_d;
      req_addr_q   <= req_addr_d;
      req_strb_q   <= req_strb_d;
      req_wdata_q  <= req_wdata_d;
      req_we_q     <= req_we_d;
      result_q     <= result_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_signals    = out_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;
  assign o_req_addr   = req_addr_q;
  assign o_req_we     = req_we_q;
  assign o_req_strb   = req_strb_q;
  assign o_req_wdata  = req_wdata_q;

endmodule
